// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 link framing path: byte type, frame FSM states
// and the default start-of-frame marker.
package rc4_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t SOF_BYTE_DEF = 8'h7E;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_HDR,
    ST_LEN,
    ST_PAY,
    ST_CHK
  } frame_state_t;

  // Trailer byte: running XOR of the payload folded with the length byte.
  function automatic byte_t chk_fold(input byte_t chk, input byte_t cnt);
    return chk ^ cnt;
  endfunction

endpackage

// File: rtl/rc4_frame_tx_if.sv
// Byte-stream bundle around the frame transmitter: ciphertext in, framed bytes out.
interface rc4_frame_tx_if;

  rc4_pkg::byte_t data_in;
  logic           valid_in;
  logic           last_in;
  logic           ready_out;
  rc4_pkg::byte_t data_out;
  logic           valid_out;
  logic           ready_in;
  logic           sof_out;
  logic           eof_out;
  rc4_pkg::byte_t frame_cnt;

  modport slave (
    input  data_in, valid_in, last_in, ready_in,
    output ready_out, data_out, valid_out, sof_out, eof_out, frame_cnt
  );

  modport master (
    output data_in, valid_in, last_in, ready_in,
    input  ready_out, data_out, valid_out, sof_out, eof_out, frame_cnt
  );

endinterface

// File: rtl/rc4_frame_buf.sv
// Payload store for one frame: synchronous write port, combinational read port.
module rc4_frame_buf
  import rc4_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  byte_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output byte_t         rdata_o
);

  byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rc4_frame_tx.sv
// Frames ciphertext bytes as SOF, LEN, payload, CHK over a valid/ready stream.
// One frame is buffered at a time; input is stalled while it is being sent.
module rc4_frame_tx
  import rc4_pkg::*;
#(
  parameter int    MAX_LEN  = 16,
  parameter byte_t SOF_BYTE = SOF_BYTE_DEF,
  parameter int    AW       = 4
) (
  input  logic           clk,
  input  logic           rst,
  rc4_frame_tx_if.slave  bus
);

  frame_state_t  state_q;
  byte_t         cnt_q, chk_q, data_q, fcnt_q;
  logic [AW-1:0] rd_q;
  logic          rdy_q, vld_q, sof_q, eof_q;

  logic          accept, xfer, close_d, pay_last;
  byte_t         cnt_d, chk_d, rdata;
  logic [AW-1:0] rd_d, raddr;

  assign accept   = bus.valid_in & rdy_q;
  assign xfer     = vld_q & bus.ready_in;
  assign cnt_d    = cnt_q + 8'd1;
  assign chk_d    = chk_q ^ bus.data_in;
  assign close_d  = bus.last_in | (cnt_d == 8'(MAX_LEN));
  assign rd_d     = rd_q + AW'(1);
  assign pay_last = (8'(rd_q) == (cnt_q - 8'd1));

  // Read address runs one ahead of rd_q so the next byte is ready to register.
  assign raddr = (state_q == ST_LEN) ? '0 : rd_d;

  rc4_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (bus.data_in),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      chk_q   <= '0;
      rd_q    <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      data_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          rdy_q <= 1'b1;
          if (accept) begin
            cnt_q <= cnt_d;
            chk_q <= chk_d;
            if (close_d) begin
              state_q <= ST_HDR;
              rdy_q   <= 1'b0;
              vld_q   <= 1'b1;
              sof_q   <= 1'b1;
              data_q  <= SOF_BYTE;
            end
          end
        end
        ST_HDR: if (xfer) begin
          state_q <= ST_LEN;
          sof_q   <= 1'b0;
          data_q  <= cnt_q;
        end
        ST_LEN: if (xfer) begin
          state_q <= ST_PAY;
          rd_q    <= '0;
          data_q  <= rdata;
        end
        ST_PAY: if (xfer) begin
          if (pay_last) begin
            state_q <= ST_CHK;
            eof_q   <= 1'b1;
            data_q  <= chk_fold(chk_q, cnt_q);
          end else begin
            rd_q   <= rd_d;
            data_q <= rdata;
          end
        end
        ST_CHK: if (xfer) begin
          state_q <= ST_COLLECT;
          vld_q   <= 1'b0;
          eof_q   <= 1'b0;
          rdy_q   <= 1'b1;
          cnt_q   <= '0;
          chk_q   <= '0;
          rd_q    <= '0;
          fcnt_q  <= fcnt_q + 8'd1;
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign bus.ready_out = rdy_q;
  assign bus.valid_out = vld_q;
  assign bus.data_out  = data_q;
  assign bus.sof_out   = sof_q;
  assign bus.eof_out   = eof_q;
  assign bus.frame_cnt = fcnt_q;

endmodule

// File: tb/tb_rc4_frame_tx.sv
// Directed + random bench for rc4_frame_tx with a queue scoreboard of framed bytes.
module tb_rc4_frame_tx;
  import rc4_pkg::*;

  localparam int MAX_LEN = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    xfers = 0;
  int    frames_seen = 0;
  exp_t  sb[$];
  byte_t cur[$];
  exp_t  mon_e;
  byte_t basic_b[5] = '{8'd5, 8'd10, 8'd20, 8'd30, 8'd40};

  rc4_frame_tx_if bus();

  rc4_frame_tx #(
    .MAX_LEN  (MAX_LEN),
    .SOF_BYTE (8'h7E),
    .AW       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected framing of the bytes collected so far: SOF, LEN, payload, LEN^xor(payload).
  task automatic push_frame();
    byte_t n, c;
    n = byte_t'(cur.size());
    c = n;
    sb.push_back('{8'h7E, 1'b1, 1'b0});
    sb.push_back('{n, 1'b0, 1'b0});
    foreach (cur[i]) begin
      sb.push_back('{cur[i], 1'b0, 1'b0});
      c = c ^ cur[i];
    end
    sb.push_back('{c, 1'b0, 1'b1});
    cur.delete();
  endtask

  task automatic send_byte(input byte_t d, input logic last, input int gap);
    bit acc;
    int guard;
    repeat (gap) begin
      bus.valid_in = 1'b0;
      bus.last_in  = 1'($urandom_range(0, 1));
      bus.data_in  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.last_in  = last;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = bus.ready_out;
      @(posedge clk);
      guard++;
    end
    #1;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    check("accept", 32'(acc), 32'd1);
    if (acc) begin
      cur.push_back(d);
      if (last || cur.size() == MAX_LEN) push_frame();
    end
  endtask

  task automatic drain(input bit rnd);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 5000) begin
      @(posedge clk); #1;
      if (rnd) bus.ready_in = 1'($urandom_range(0, 1));
      guard++;
    end
    bus.ready_in = 1'b1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"},  32'(bus.ready_out), 32'd0);
    check({tag, "_vld"},  32'(bus.valid_out), 32'd0);
    check({tag, "_sof"},  32'(bus.sof_out),   32'd0);
    check({tag, "_eof"},  32'(bus.eof_out),   32'd0);
    check({tag, "_data"}, 32'(bus.data_out),  32'd0);
    check({tag, "_fcnt"}, 32'(bus.frame_cnt), 32'd0);
  endtask

  // Output monitor: every transfer is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.valid_out) begin
        check("rdy_while_tx", 32'(bus.ready_out), 32'd0);
        if (bus.ready_in) begin
          if (sb.size() == 0) begin
            check("unexpected_byte", 32'(sb.size()), 32'd1);
          end else begin
            mon_e = sb.pop_front();
            check("data", 32'(bus.data_out), 32'(mon_e.data));
            check("sof",  32'(bus.sof_out),  32'(mon_e.sof));
            check("eof",  32'(bus.eof_out),  32'(mon_e.eof));
            xfers++;
            if (bus.eof_out) frames_seen++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, guard, len;
    bit last;
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    bus.ready_in = 1'b1;

    // Reset state and ready_out rising one cycle after release
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rdy_before_rise", 32'(bus.ready_out), 32'd0);
    @(negedge clk);
    check("rdy_after_rise", 32'(bus.ready_out), 32'd1);
    @(posedge clk); #1;

    // Basic frame
    for (int i = 0; i < 5; i++) send_byte(basic_b[i], i == 4, 0);
    drain(0);
    check("fcnt_basic", 32'(bus.frame_cnt), 32'd1);

    // Max length: 0..15 closes by length, 16..19 stay open for the next frame
    for (int i = 0; i < 20; i++) send_byte(byte_t'(i), 1'b0, 0);
    drain(0);
    check("fcnt_maxlen", 32'(bus.frame_cnt), 32'd2);
    check("maxlen_open", 32'(cur.size()), 32'd4);

    // Backpressure while payload byte 0x14 is showing
    send_byte(8'd10, 1'b0, 0);
    send_byte(8'd20, 1'b0, 0);
    send_byte(8'd30, 1'b1, 0);
    guard = 0;
    while (!(bus.valid_out && bus.data_out == 8'h14 && !bus.sof_out && !bus.eof_out) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("bp_found", 32'(bus.data_out), 32'h14);
    bus.ready_in = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_data", 32'(bus.data_out), 32'h14);
      check("bp_hold_vld",  32'(bus.valid_out), 32'd1);
    end
    bus.ready_in = 1'b1;
    drain(0);
    check("fcnt_bp", 32'(bus.frame_cnt), 32'd3);

    // Single-byte frame
    send_byte(8'hAA, 1'b1, 0);
    drain(0);
    check("fcnt_single", 32'(bus.frame_cnt), 32'd4);

    // Reset after two payload bytes have been sent
    base = xfers;
    for (int i = 1; i <= 4; i++) send_byte(byte_t'(i), i == 4, 0);
    guard = 0;
    while (xfers < base + 4 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rst_reach_pay", 32'(xfers - base), 32'd4);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    sb.delete();
    cur.delete();
    @(posedge clk); #1 rst = 1'b0;
    frames_seen = 0;
    send_byte(8'h33, 1'b1, 0);
    drain(0);
    check("fcnt_after_rst", 32'(bus.frame_cnt), 32'd1);

    // Random frames with input gaps and random downstream stalls
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, MAX_LEN);
      for (int i = 0; i < len; i++) begin
        last = (i == len - 1) && ((len < MAX_LEN) || ($urandom_range(0, 1) == 1));
        send_byte(8'($urandom), last, $urandom_range(0, 2));
      end
      drain(1);
    end
    check("fcnt_random", 32'(bus.frame_cnt), 32'd201);
    check("frames_seen", 32'(frames_seen), 32'd201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
